// File: rtl/ex_pkg.sv
// Shared constants and types for the execute-stage sequencing controller.
// Opcode/function encodings, FSM states and shifter direction codes.
package ex_pkg;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_REG = 7'b0110011;

  // {funct7, funct3} keys for R-type operations
  localparam logic [9:0] FN_ADD = 10'b0000000_000;
  localparam logic [9:0] FN_SUB = 10'b0100000_000;
  localparam logic [9:0] FN_AND = 10'b0000000_111;
  localparam logic [9:0] FN_OR  = 10'b0000000_110;
  localparam logic [9:0] FN_SLL = 10'b0000000_001;
  localparam logic [9:0] FN_SRL = 10'b0000000_101;
  localparam logic [9:0] FN_SRA = 10'b0100000_101;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  typedef enum logic [1:0] {
    SH_LL,
    SH_RL,
    SH_RA
  } shift_dir_e;

endpackage

// File: rtl/ex_iter_shifter.sv
// Iterative shifter: operand register, remaining-shift counter and a step
// shifter moving up to SHIFT_STEP bit positions per cycle.
module ex_iter_shifter
  import ex_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 1,
  parameter int SHAMT_W    = $clog2(XLEN)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [XLEN-1:0]    operand,
  input  logic [SHAMT_W-1:0] shamt,
  input  shift_dir_e         dir,
  output logic               last,
  output logic [XLEN-1:0]    result_next
);

  localparam logic [SHAMT_W-1:0] STEP_AMT = SHAMT_W'(SHIFT_STEP);

  logic [XLEN-1:0]    op_q;
  logic [SHAMT_W-1:0] cnt_q;
  shift_dir_e         dir_q;
  logic [SHAMT_W-1:0] amt;
  logic [XLEN-1:0]    shifted;

  // NOTE: every signal written in always_comb gets a default first so no path leaves it unassigned (which would infer a latch).
  always_comb begin
    amt     = (cnt_q < STEP_AMT) ? cnt_q : STEP_AMT;
    shifted = op_q << amt;
    case (dir_q)
      SH_RL:   shifted = op_q >> amt;
      SH_RA:   shifted = XLEN'($signed(op_q) >>> amt);
      default: shifted = op_q << amt;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q  <= '0;
      cnt_q <= '0;
      dir_q <= SH_LL;
    end else if (start) begin
      op_q  <= operand;
      cnt_q <= shamt;
      dir_q <= dir;
    end else if (cnt_q != '0) begin
      op_q  <= shifted;
      cnt_q <= cnt_q - amt;
    end
  end

  // Final step is the one that drains the counter; the controller captures it directly.
  assign last        = (cnt_q != '0) && (cnt_q <= STEP_AMT);
  assign result_next = shifted;

endmodule

// File: rtl/ex_seq_ctrl.sv
// Execute-stage sequencing controller: decode, FSM and held output register.
// Optional SRL/SRA support through the iterative shifter when EX_SRL_SRA_EN is defined.
module ex_seq_ctrl
  import ex_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] read_data1,
  input  logic [XLEN-1:0] read_data2,
  input  logic [XLEN-1:0] imm,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_result,
  output logic            illegal,
  output logic            busy
);

  localparam int SHAMT_W = $clog2(XLEN);

  state_e state_q, state_d;

  logic               accept;
  logic [XLEN-1:0]    dec_result;
  logic               dec_illegal;
  logic               dec_shift;
  shift_dir_e         dec_dir;
  logic [SHAMT_W-1:0] dec_shamt;

  logic               sh_start;
  logic               sh_last;
  logic [XLEN-1:0]    sh_result;

  logic               load;
  logic [XLEN-1:0]    load_result;
  logic               load_illegal;
  logic [XLEN-1:0]    result_q;
  logic               illegal_q;

  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign dec_shamt = read_data2[SHAMT_W-1:0];

  always_comb begin
    dec_result  = '0;
    dec_illegal = 1'b0;
    dec_shift   = 1'b0;
    dec_dir     = SH_LL;
    case (opcode)
      OP_IMM: dec_result = read_data1 + imm;
      OP_REG: begin
        case ({funct7, funct3})
          FN_ADD: dec_result = read_data1 + read_data2;
          FN_SUB: dec_result = read_data1 - read_data2;
          FN_AND: dec_result = read_data1 & read_data2;
          FN_OR:  dec_result = read_data1 | read_data2;
          // Shift encodings pass rs1 through so a zero shamt completes in one cycle.
          FN_SLL: begin
            dec_shift  = 1'b1;
            dec_result = read_data1;
          end
`ifdef EX_SRL_SRA_EN
          FN_SRL: begin
            dec_shift  = 1'b1;
            dec_dir    = SH_RL;
            dec_result = read_data1;
          end
          FN_SRA: begin
            dec_shift  = 1'b1;
            dec_dir    = SH_RA;
            dec_result = read_data1;
          end
`endif
          default: dec_illegal = 1'b1;
        endcase
      end
      default: dec_result = '0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    sh_start     = 1'b0;
    load         = 1'b0;
    load_result  = dec_result;
    load_illegal = dec_illegal;
    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          if (dec_shift && (dec_shamt != '0)) begin
            state_d  = SHIFT;
            sh_start = 1'b1;
          end else begin
            state_d = DONE;
            load    = 1'b1;
          end
        end else if (state_q == DONE && out_ready) begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (sh_last) begin
          state_d      = DONE;
          load         = 1'b1;
          load_result  = sh_result;
          load_illegal = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      result_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) begin
        result_q  <= load_result;
        illegal_q <= load_illegal;
      end
    end
  end

  ex_iter_shifter #(
    .XLEN      (XLEN),
    .SHIFT_STEP(SHIFT_STEP),
    .SHAMT_W   (SHAMT_W)
  ) u_shifter (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (sh_start),
    .operand    (read_data1),
    .shamt      (dec_shamt),
    .dir        (dec_dir),
    .last       (sh_last),
    .result_next(sh_result)
  );

  assign out_valid  = (state_q == DONE);
  assign alu_result = result_q;
  assign illegal    = illegal_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_ex_seq_ctrl.sv
// Directed self-checking bench for ex_seq_ctrl (SHIFT_STEP 1 and 4 instances).
// SRL/SRA expectations follow EX_SRL_SRA_EN.
module tb_ex_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_valid4;
  logic        in_ready, in_ready4;
  logic [31:0] read_data1, read_data2, imm;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic        out_valid, out_valid4;
  logic        out_ready, out_ready4;
  logic [31:0] alu_result, alu_result4;
  logic        illegal, illegal4;
  logic        busy, busy4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ex_seq_ctrl #(.XLEN(32), .SHIFT_STEP(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .read_data1(read_data1), .read_data2(read_data2), .imm(imm),
    .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .out_valid(out_valid), .out_ready(out_ready), .alu_result(alu_result),
    .illegal(illegal), .busy(busy)
  );

  ex_seq_ctrl #(.XLEN(32), .SHIFT_STEP(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .read_data1(read_data1), .read_data2(read_data2), .imm(imm),
    .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .out_valid(out_valid4), .out_ready(out_ready4), .alu_result(alu_result4),
    .illegal(illegal4), .busy(busy4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [6:0] op, input logic [6:0] f7, input logic [2:0] f3,
                       input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] im);
    opcode     = op;
    funct7     = f7;
    funct3     = f3;
    read_data1 = rs1;
    read_data2 = rs2;
    imm        = im;
  endtask

  initial begin
    logic saw_valid;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_valid4  = 1'b0;
    out_ready  = 1'b1;
    out_ready4 = 1'b1;
    drive(7'h00, 7'h00, 3'h0, 32'h0, 32'h0, 32'h0);
    tick();
    tick();

    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_alu_result", alu_result, 32'h0);
    check("rst_illegal", {31'b0, illegal}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_out_valid4", {31'b0, out_valid4}, 32'd0);
    rst_n = 1'b1;
    tick();
    check("idle_in_ready", {31'b0, in_ready}, 32'd1);

    // ADD 5 + 3
    drive(7'b0110011, 7'b0000000, 3'b000, 32'h5, 32'h3, 32'h0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    drive(7'b0110011, 7'b0000000, 3'b000, 32'hDEAD, 32'hBEEF, 32'h0);
    check("add_valid", {31'b0, out_valid}, 32'd1);
    check("add_result", alu_result, 32'h8);
    check("add_illegal", {31'b0, illegal}, 32'd0);
    tick();
    check("add_retired", {31'b0, out_valid}, 32'd0);
    check("add_idle_busy", {31'b0, busy}, 32'd0);

    // SUB then OR back-to-back
    drive(7'b0110011, 7'b0100000, 3'b000, 32'h5, 32'h3, 32'h0);
    in_valid = 1'b1;
    tick();
    check("sub_result", alu_result, 32'h2);
    check("sub_valid", {31'b0, out_valid}, 32'd1);
    check("sub_in_ready", {31'b0, in_ready}, 32'd1);
    drive(7'b0110011, 7'b0000000, 3'b110, 32'hF0, 32'h0F, 32'h0);
    tick();
    in_valid = 1'b0;
    check("or_result", alu_result, 32'hFF);
    check("or_valid", {31'b0, out_valid}, 32'd1);
    tick();

    // SLL 1 << 5, SHIFT_STEP=1: busy for 5 cycles, valid after 6 edges
    drive(7'b0110011, 7'b0000000, 3'b001, 32'h1, 32'h25, 32'h0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    drive(7'b0110011, 7'b0000000, 3'b001, 32'hFFFF_FFFF, 32'h0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("sll_in_ready_%0d", i), {31'b0, in_ready}, 32'd0);
      check($sformatf("sll_not_valid_%0d", i), {31'b0, out_valid}, 32'd0);
      tick();
    end
    check("sll_valid", {31'b0, out_valid}, 32'd1);
    check("sll_result", alu_result, 32'h20);
    tick();

    // Same SLL on the SHIFT_STEP=4 instance: valid after 3 edges
    drive(7'b0110011, 7'b0000000, 3'b001, 32'h1, 32'h25, 32'h0);
    in_valid4 = 1'b1;
    tick();
    in_valid4 = 1'b0;
    check("sll4_wait1", {31'b0, out_valid4}, 32'd0);
    tick();
    check("sll4_wait2", {31'b0, out_valid4}, 32'd0);
    tick();
    check("sll4_valid", {31'b0, out_valid4}, 32'd1);
    check("sll4_result", alu_result4, 32'h20);
    tick();

    // SLL with shamt 0 completes in one cycle
    drive(7'b0110011, 7'b0000000, 3'b001, 32'h1234_5678, 32'h20, 32'h0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("sll0_valid", {31'b0, out_valid}, 32'd1);
    check("sll0_result", alu_result, 32'h1234_5678);
    tick();

    // Backpressure on ADDI 0x10 + 0xFFFF_FFFF
    out_ready = 1'b0;
    drive(7'b0010011, 7'b1111111, 3'b101, 32'h10, 32'h0, 32'hFFFF_FFFF);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    drive(7'b0110011, 7'b0000000, 3'b000, 32'h99, 32'h99, 32'h99);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("bp_valid_%0d", i), {31'b0, out_valid}, 32'd1);
      check($sformatf("bp_result_%0d", i), alu_result, 32'h0000_000F);
      check($sformatf("bp_in_ready_%0d", i), {31'b0, in_ready}, 32'd0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", {31'b0, in_ready}, 32'd1);
    tick();
    check("bp_retired", {31'b0, out_valid}, 32'd0);

    // Illegal R-type encoding
    drive(7'b0110011, 7'b0000001, 3'b000, 32'h7, 32'h9, 32'h0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("ill_valid", {31'b0, out_valid}, 32'd1);
    check("ill_flag", {31'b0, illegal}, 32'd1);
    check("ill_result", alu_result, 32'h0);
    tick();

    // Unknown opcode: zero result, not illegal
    drive(7'b0000011, 7'b0000000, 3'b010, 32'h7, 32'h9, 32'h5);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("unk_valid", {31'b0, out_valid}, 32'd1);
    check("unk_illegal", {31'b0, illegal}, 32'd0);
    check("unk_result", alu_result, 32'h0);
    tick();

    // SRA 0x8000_0000 by 4
    drive(7'b0110011, 7'b0100000, 3'b101, 32'h8000_0000, 32'h4, 32'h0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
`ifdef EX_SRL_SRA_EN
    drive(7'b0110011, 7'b0000000, 3'b000, 32'h0, 32'h0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("sra_not_valid_%0d", i), {31'b0, out_valid}, 32'd0);
      tick();
    end
    check("sra_valid", {31'b0, out_valid}, 32'd1);
    check("sra_result", alu_result, 32'hF800_0000);
    check("sra_illegal", {31'b0, illegal}, 32'd0);
    tick();
    drive(7'b0110011, 7'b0000000, 3'b101, 32'h8000_0000, 32'h4, 32'h0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("srl_valid", {31'b0, out_valid}, 32'd1);
    check("srl_result", alu_result, 32'h0800_0000);
    tick();
`else
    check("sra_disabled_valid", {31'b0, out_valid}, 32'd1);
    check("sra_disabled_illegal", {31'b0, illegal}, 32'd1);
    check("sra_disabled_result", alu_result, 32'h0);
    tick();
`endif

    // AND leaves a nonzero result ahead of the reset test
    drive(7'b0110011, 7'b0000000, 3'b111, 32'h0000_F0F0, 32'h0000_FF00, 32'h0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("and_result", alu_result, 32'h0000_F000);
    tick();

    // Reset two cycles into SLL by 20
    drive(7'b0110011, 7'b0000000, 3'b001, 32'h1, 32'd20, 32'h0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check("mid_shift_busy", {31'b0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mrst_out_valid", {31'b0, out_valid}, 32'd0);
    check("mrst_busy", {31'b0, busy}, 32'd0);
    check("mrst_result", alu_result, 32'h0);
    tick();
    tick();
    check("mrst_hold_result", alu_result, 32'h0);
    rst_n = 1'b1;
    saw_valid = 1'b0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (out_valid !== 1'b0 || busy !== 1'b0) saw_valid = 1'b1;
    end
    check("mrst_no_late_valid", {31'b0, saw_valid}, 32'd0);

    // ADD after reset, with carry discarded
    drive(7'b0110011, 7'b0000000, 3'b000, 32'hFFFF_FFFF, 32'h2, 32'h0);
    in_valid = 1'b1;
    tick();
    check("post_add_valid", {31'b0, out_valid}, 32'd1);
    check("post_add_result", alu_result, 32'h1);
    // SUB borrow wrap, accepted in the same cycle the ADD retires
    drive(7'b0110011, 7'b0100000, 3'b000, 32'h0, 32'h1, 32'h0);
    tick();
    in_valid = 1'b0;
    check("post_sub_result", alu_result, 32'hFFFF_FFFF);
    check("post_sub_valid", {31'b0, out_valid}, 32'd1);
    tick();
    check("post_idle", {31'b0, out_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
